program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, program memory depth in words.
REQ-002 SHALL have parameter AW, default 5, program memory address width (2**AW == DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have ports load_start / run_start / clear  input  1 each  single-cycle command pulses.
REQ-006 SHALL have ports load_valid  input  1, load_data  input  32, load_ready  output  1  program load handshake.
REQ-007 SHALL have ports pmem_we  output  1, pmem_addr  output  AW, pmem_wdata  output  32  program memory write port.
REQ-008 SHALL have ports core_reset  output  1, core_ce  output  1  core reset and clock enable.
REQ-009 SHALL have ports core_pc  input  32, stop_pc  input  32, max_cycles  input  8  run control.
REQ-010 SHALL have ports busy  output  1, load_done  output  1, halted  output  1, halt_cause  output  2, cycle_count  output  9  status.

Function
REQ-011 SHALL implement states IDLE, LOAD, RUN, HALTED (plus STEP when configured).
REQ-012 IDLE: core_reset=1, core_ce=0, load_ready=0, busy=0; load_start -> LOAD with word counter=0; run_start -> RUN latching stop_pc and max_cycles, cycle_count=0; load_start and run_start in the same cycle -> LOAD.
REQ-013 LOAD: load_ready=1, busy=1, core_reset=1; pmem_we = load_valid & load_ready combinationally, pmem_addr = word counter, pmem_wdata = load_data, zero latency.
REQ-014 LOAD: word counter SHALL increment on each accepted word; acceptance at address DEPTH-1 -> IDLE with load_done=1 for exactly one cycle; counter wraps to 0.
REQ-015 RUN: core_reset=0, core_ce=1, busy=1; cycle_count increments by 1 each RUN cycle.
REQ-016 RUN: core_pc == latched stop_pc -> HALTED, halt_cause=2'b01; that cycle's core_ce SHALL be 0, so the instruction at stop_pc is not executed.
REQ-017 RUN: cycle_count+1 == latched max_cycles, with max_cycles==0 meaning 256, -> HALTED, halt_cause=2'b10 after exactly max_cycles enabled cycles.
REQ-018 PC match and cycle limit in the same cycle SHALL give halt_cause=2'b01.
REQ-019 HALTED: core_reset=0, core_ce=0 (core state frozen for inspection), halted=1, busy=0; clear -> IDLE with halt_cause=0; all other commands ignored.
REQ-020 load_start and run_start SHALL be ignored outside IDLE; clear SHALL be ignored outside HALTED.
REQ-021 cycle_count SHALL hold its value in HALTED and reset to 0 on entering RUN or IDLE.

Reset
REQ-022 reset SHALL, in any state including mid-LOAD or mid-RUN, force IDLE on the next edge: core_reset=1, core_ce=0, load_ready=0, pmem_we=0, busy=0, load_done=0, halted=0, halt_cause=0, cycle_count=0, word counter=0.
REQ-023 reset SHALL take priority over every command input in the same cycle.

Configuration
REQ-024 Macro SEQ_SINGLE_STEP_EN defined: input step_mode (1) and step (1) pulse SHALL exist; run_start with step_mode=1 -> STEP state (core_reset=0, core_ce=0, busy=1); each step pulse gives core_ce=1 for exactly one cycle and increments cycle_count; the halt rules of REQ-016..018 apply to stepped cycles; clear in STEP -> HALTED with halt_cause=2'b11.
REQ-025 Macro SEQ_SINGLE_STEP_EN undefined: no step_mode/step ports, no STEP state; run_start always enters RUN.

Verification
REQ-026 Load: load_start, then 32 words 0x00000013 with load_valid held high -> 32 pmem_we pulses at addresses 0..31, load_done high one cycle after word 31, state IDLE.
REQ-027 Backpressure: load_valid toggled 1/0 for 64 cycles -> exactly 32 writes, addresses strictly increasing with no gaps.
REQ-028 Cycle limit: max_cycles=10, stop_pc=0xFFFFFFFF, run_start -> core_ce high exactly 10 cycles, halted=1, halt_cause=2'b10, cycle_count=10; clear -> IDLE, core_reset=1.
REQ-029 PC stop: stop_pc=0x10 with core_pc advancing by 4 from 0 -> HALTED with halt_cause=2'b01 after 4 enabled cycles; same cycle as the limit (max_cycles=5, stop_pc=0x10) -> 2'b01.
REQ-030 Reset mid-operation: reset asserted at word 7 of a load and again at cycle 3 of a run -> IDLE next edge with all REQ-022 values; a new load restarts at address 0.
REQ-031 Step (macro defined): step_mode=1, run_start, 3 step pulses -> core_ce high exactly 3 single cycles, cycle_count=3; clear -> HALTED with halt_cause=2'b11.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer
//   Loads a program into the core's instruction memory, then runs the core
//   until it reaches a stop PC or a cycle budget, and freezes it for inspection.
//
//   Optional feature: define SEQ_SINGLE_STEP_EN to add single-step execution
//   (ports step_mode/step and a STEP state).
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   load_start/run_start/clear  single-cycle command pulses
//   load_valid/load_data/load_ready   program word handshake
//   pmem_we/pmem_addr/pmem_wdata      program memory write port
//   core_reset/core_ce          core reset and clock enable
//   core_pc/stop_pc/max_cycles  run control (stop_pc/max_cycles latched on run_start)
//   busy/load_done/halted/halt_cause/cycle_count   status
//   step_mode/step              (SEQ_SINGLE_STEP_EN only) single-step control
module program_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          run_start,
  input  logic          clear,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          pmem_we,
  output logic [AW-1:0] pmem_addr,
  output logic [31:0]   pmem_wdata,
  output logic          core_reset,
  output logic          core_ce,
  input  logic [31:0]   core_pc,
  input  logic [31:0]   stop_pc,
  input  logic [7:0]    max_cycles,
  output logic          busy,
  output logic          load_done,
  output logic          halted,
  output logic [1:0]    halt_cause,
  output logic [8:0]    cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_HALTED = 3'd3
`ifdef SEQ_SINGLE_STEP_EN
    , ST_STEP = 3'd4
`endif
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    cause_nxt_s;
  logic [AW-1:0] wcnt_r;
  logic [31:0]   stop_pc_r;
  logic [7:0]    max_cycles_r;
  logic [8:0]    cycle_count_r;
  logic [1:0]    halt_cause_r;
  logic          load_done_r;
  logic          accept_s;
  logic          last_word_s;
  logic          pc_match_s;
  logic          lim_hit_s;
  logic [8:0]    limit_s;

  // A stored budget of 0 stands for 256 cycles.
  assign limit_s     = (max_cycles_r == 8'd0) ? 9'd256 : {1'b0, max_cycles_r};
  assign lim_hit_s   = ((cycle_count_r + 9'd1) == limit_s);
  assign pc_match_s  = (core_pc == stop_pc_r);
  assign accept_s    = (state_r == ST_LOAD) && load_valid;
  assign last_word_s = (wcnt_r == LAST_ADDR);

  assign cycle_count = cycle_count_r;
  assign halt_cause  = halt_cause_r;
  assign load_done   = load_done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and halt-cause selection; a PC match outranks the cycle budget.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = halt_cause_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt_s = ST_LOAD;
`ifdef SEQ_SINGLE_STEP_EN
        end else if (run_start) begin
          state_nxt_s = step_mode ? ST_STEP : ST_RUN;
`else
        end else if (run_start) begin
          state_nxt_s = ST_RUN;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s && last_word_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (pc_match_s) begin
          state_nxt_s = ST_HALTED;
          cause_nxt_s = 2'b01;
        end else if (lim_hit_s) begin
          state_nxt_s = ST_HALTED;
          cause_nxt_s = 2'b10;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
          cause_nxt_s = 2'b00;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_STEP: begin
        if (clear) begin
          state_nxt_s = ST_HALTED;
          cause_nxt_s = 2'b11;
        end else if (step && pc_match_s) begin
          state_nxt_s = ST_HALTED;
          cause_nxt_s = 2'b01;
        end else if (step && lim_hit_s) begin
          state_nxt_s = ST_HALTED;
          cause_nxt_s = 2'b10;
        end else begin
          state_nxt_s = ST_STEP;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
        cause_nxt_s = 2'b00;
      end
    endcase
  end

  // Output decode; core_ce drops in the very cycle core_pc reaches stop_pc.
  always_comb begin
    core_reset = 1'b1;
    core_ce    = 1'b0;
    load_ready = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        core_reset = 1'b1;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_RUN: begin
        core_reset = 1'b0;
        core_ce    = ~pc_match_s;
        busy       = 1'b1;
      end
      ST_HALTED: begin
        core_reset = 1'b0;
        halted     = 1'b1;
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_STEP: begin
        core_reset = 1'b0;
        core_ce    = step & ~clear & ~pc_match_s;
        busy       = 1'b1;
      end
`endif
      default: begin
        core_reset = 1'b1;
      end
    endcase
  end

  assign pmem_we    = accept_s;
  assign pmem_addr  = wcnt_r;
  assign pmem_wdata = load_data;

  // Word counter, run parameters, cycle counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_r        <= '0;
      stop_pc_r     <= 32'd0;
      max_cycles_r  <= 8'd0;
      cycle_count_r <= 9'd0;
      halt_cause_r  <= 2'b00;
      load_done_r   <= 1'b0;
    end else begin
      halt_cause_r <= cause_nxt_s;
      load_done_r  <= accept_s && last_word_s;
      if ((state_r == ST_IDLE) && load_start) begin
        wcnt_r <= '0;
      end else if (accept_s) begin
        wcnt_r <= wcnt_r + AW'(1);
      end else begin
        wcnt_r <= wcnt_r;
      end
      if ((state_r == ST_IDLE) && run_start && !load_start) begin
        stop_pc_r    <= stop_pc;
        max_cycles_r <= max_cycles;
      end else begin
        stop_pc_r    <= stop_pc_r;
        max_cycles_r <= max_cycles_r;
      end
      // Held at zero throughout IDLE, so every run starts counting from 0.
      if ((state_r == ST_IDLE) || (state_nxt_s == ST_IDLE)) begin
        cycle_count_r <= 9'd0;
      end else if (core_ce) begin
        cycle_count_r <= cycle_count_r + 9'd1;
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic        run_start = 1'b0;
  logic        clear = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
`endif
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        load_ready;
  logic        pmem_we;
  logic [4:0]  pmem_addr;
  logic [31:0] pmem_wdata;
  logic        core_reset;
  logic        core_ce;
  logic [31:0] core_pc = 32'd0;
  logic [31:0] stop_pc = 32'hFFFF_FFFF;
  logic [7:0]  max_cycles = 8'd0;
  logic        busy;
  logic        load_done;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [8:0]  cycle_count;

  int n_chk = 0;
  int n_fail = 0;

  program_sequencer #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .run_start(run_start), .clear(clear),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .pmem_we(pmem_we), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .core_reset(core_reset), .core_ce(core_ce),
    .core_pc(core_pc), .stop_pc(stop_pc), .max_cycles(max_cycles),
    .busy(busy), .load_done(load_done), .halted(halted),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Monitors: record memory writes and enabled core cycles mid-cycle.
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          ce_cnt = 0;
  logic        ce_neg = 1'b0;
  logic        pc_rst = 1'b1;

  always @(negedge clk) begin
    if (pmem_we) begin
      wa_q.push_back(int'(pmem_addr));
      wd_q.push_back(pmem_wdata);
    end
    if (core_ce) ce_cnt <= ce_cnt + 1;
    ce_neg <= core_ce;
  end

  // Core model: PC advances by 4 on every enabled cycle.
  always @(posedge clk) begin
    if (pc_rst) core_pc <= 32'd0;
    else if (ce_neg) core_pc <= core_pc + 32'd4;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_core_reset"}, core_reset, 1'b1);
    check_eq({tag, "_core_ce"}, core_ce, 1'b0);
    check_eq({tag, "_load_ready"}, load_ready, 1'b0);
    check_eq({tag, "_pmem_we"}, pmem_we, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_load_done"}, load_done, 1'b0);
    check_eq({tag, "_halted"}, halted, 1'b0);
    check_eq({tag, "_cause"}, halt_cause, 2'b00);
    check_eq({tag, "_count"}, cycle_count, 9'd0);
  endtask

  // Start a run, then scramble the run inputs to prove they were latched.
  task automatic do_run(input logic [31:0] sp, input logic [7:0] mc, output int n, output int ce_n);
    int base;
    stop_pc = sp;
    max_cycles = mc;
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    stop_pc = 32'd0;
    max_cycles = 8'd1;
    base = ce_cnt;
    n = 0;
    while (!halted && n < 300) begin
      cyc();
      n++;
    end
    check_eq("run_halted", halted, 1'b1);
    ce_n = ce_cnt - base;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ce_n, base, errs;

    // Reset state
    cyc(); cyc();
    check_idle("rst");
    reset = 1'b0;
    cyc();
    check_idle("post_rst");

    // Full load of 32 words with load_valid held high
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 32'h0000_0013;
    base = wa_q.size();
    #1;
    check_eq("load_ready", load_ready, 1'b1);
    check_eq("load_busy", busy, 1'b1);
    check_eq("load_core_reset", core_reset, 1'b1);
    check_eq("load_we", pmem_we, 1'b1);
    for (int i = 0; i < 32; i++) begin
      check_eq("load_addr", pmem_addr, i[4:0]);
      cyc();
    end
    load_valid = 1'b0;
    check_eq("load_done_pulse", load_done, 1'b1);
    check_eq("load_end_busy", busy, 1'b0);
    check_eq("load_end_ready", load_ready, 1'b0);
    cyc();
    check_eq("load_done_clr", load_done, 1'b0);
    check_eq("load_nwrites", wa_q.size() - base, 32);
    errs = 0;
    for (int k = 0; k < 32; k++) begin
      if (wa_q[base + k] != k || wd_q[base + k] != 32'h0000_0013) errs++;
    end
    check_eq("load_seq", errs, 0);

    // Backpressure: load_valid toggles 1/0 for 64 cycles
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    base = wa_q.size();
    for (int i = 0; i < 64; i++) begin
      load_valid = (i % 2 == 0);
      cyc();
    end
    load_valid = 1'b0;
    check_eq("bp_nwrites", wa_q.size() - base, 32);
    errs = 0;
    for (int k = 0; k < 32; k++) begin
      if (wa_q[base + k] != k) errs++;
    end
    check_eq("bp_addr_seq", errs, 0);
    check_eq("bp_idle", busy, 1'b0);

    // Cycle limit of 10, stop_pc unreachable, PC held at 0
    pc_rst = 1'b1;
    do_run(32'hFFFF_FFFF, 8'd10, n, ce_n);
    check_eq("lim_edges", n, 10);
    check_eq("lim_ce_cycles", ce_n, 10);
    check_eq("lim_cause", halt_cause, 2'b10);
    check_eq("lim_count", cycle_count, 9'd10);
    check_eq("lim_ce_off", core_ce, 1'b0);
    check_eq("lim_busy", busy, 1'b0);
    check_eq("lim_core_reset", core_reset, 1'b0);
    load_start = 1'b1;
    run_start = 1'b1;
    cyc();
    load_start = 1'b0;
    run_start = 1'b0;
    check_eq("halt_ignore_cmd", halted, 1'b1);
    check_eq("halt_hold_count", cycle_count, 9'd10);
    do_clear();
    check_idle("lim_clear");

    // Budget 0 means 256 cycles
    do_run(32'hFFFF_FFFF, 8'd0, n, ce_n);
    check_eq("lim256_ce_cycles", ce_n, 256);
    check_eq("lim256_count", cycle_count, 9'd256);
    check_eq("lim256_cause", halt_cause, 2'b10);
    do_clear();

    // PC stop at 0x10 with PC advancing by 4
    pc_rst = 1'b0;
    do_run(32'h0000_0010, 8'd0, n, ce_n);
    check_eq("pc_ce_cycles", ce_n, 4);
    check_eq("pc_cause", halt_cause, 2'b01);
    check_eq("pc_frozen", core_pc, 32'h0000_0010);
    do_clear();
    pc_rst = 1'b1;
    cyc();
    pc_rst = 1'b0;

    // PC stop and cycle limit coincide
    do_run(32'h0000_0010, 8'd5, n, ce_n);
    check_eq("both_ce_cycles", ce_n, 4);
    check_eq("both_cause", halt_cause, 2'b01);
    do_clear();
    pc_rst = 1'b1;

    // Reset at word 7 of a load, with load_valid still high
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    check_eq("mid_load_addr", pmem_addr, 5'd7);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_idle("rst_load");
    load_valid = 1'b0;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    load_valid = 1'b1;
    #1;
    check_eq("reload_addr0", pmem_addr, 5'd0);
    check_eq("reload_we", pmem_we, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    load_valid = 1'b0;

    // Reset at cycle 3 of a run; clear is ignored while running
    stop_pc = 32'hFFFF_FFFF;
    max_cycles = 8'd0;
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc(); cyc();
    check_eq("run_clear_ignored", busy, 1'b1);
    check_eq("run_count3", cycle_count, 9'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_idle("rst_run");

    // Reset outranks a command in the same cycle
    reset = 1'b1;
    load_start = 1'b1;
    cyc();
    reset = 1'b0;
    load_start = 1'b0;
    check_eq("rst_prio", load_ready, 1'b0);

    // load_start and run_start together choose LOAD
    load_start = 1'b1;
    run_start = 1'b1;
    cyc();
    load_start = 1'b0;
    run_start = 1'b0;
    check_eq("both_cmd_load", load_ready, 1'b1);
    check_eq("both_cmd_core_reset", core_reset, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: three pulses, then clear
    step_mode = 1'b1;
    stop_pc = 32'hFFFF_FFFF;
    max_cycles = 8'd0;
    run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    step_mode = 1'b0;
    base = ce_cnt;
    check_eq("step_busy", busy, 1'b1);
    check_eq("step_ce_idle", core_ce, 1'b0);
    check_eq("step_core_reset", core_reset, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      #1;
      check_eq("step_ce_on", core_ce, 1'b1);
      cyc();
      step = 1'b0;
      cyc();
    end
    check_eq("step_ce_cycles", ce_cnt - base, 3);
    check_eq("step_count", cycle_count, 9'd3);
    do_clear();
    check_eq("step_halted", halted, 1'b1);
    check_eq("step_cause", halt_cause, 2'b11);
    do_clear();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
